// File: rtl/shift_unit_if.sv
// Handshake and data bundle between the multicycle control FSM and the shift unit.
interface shift_unit_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SHAMT_WIDTH = 4
);
    logic                   start;
    logic [2:0]             op;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  result;
    logic                   op_err;

    // Requester side (control FSM / testbench)
    modport master (
        output start, op, shamt, data_in,
        input  busy, done, result, op_err
    );

    // Shift unit side
    modport slave (
        input  start, op, shamt, data_in,
        output busy, done, result, op_err
    );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL/ROR by a variable amount, up to STEP
// positions per clock, plus a single-cycle fixed shift-by-2 for PC offsets.
module shift_unit #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SHAMT_WIDTH = 4,
    parameter int unsigned STEP        = 1
) (
    input  logic         clk,
    input  logic         reset,
    shift_unit_if.slave  bus
);
    // One extra bit so the rotate complement (DATA_WIDTH - n) is representable
    localparam int unsigned WRAP_WIDTH = SHAMT_WIDTH + 1;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_SL2 = 3'b101;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shiftStateT;

    shiftStateT             state;
    logic [DATA_WIDTH-1:0]  work;
    logic [2:0]             opCode;
    logic [SHAMT_WIDTH-1:0] remaining;
    logic                   busyQ;
    logic                   doneQ;
    logic [DATA_WIDTH-1:0]  resultQ;
    logic                   opErrQ;

    logic [SHAMT_WIDTH-1:0] stepN;
    logic [WRAP_WIDTH-1:0]  wrapAmt;
    logic [DATA_WIDTH-1:0]  stepped;
    logic                   lastStep;
    logic                   opIllegal;
    logic                   startOneShot;

    assign bus.busy   = busyQ;
    assign bus.done   = doneQ;
    assign bus.result = resultQ;
    assign bus.op_err = opErrQ;

    // Incoming opcode finishes in one edge (fixed SL2 or illegal): no count to load
    assign startOneShot = (bus.op >= OP_SL2);

    // Latched opcode is outside the legal range
    assign opIllegal = (opCode > OP_SL2);

    // Positions applied this edge and the value the work register moves to
    always_comb begin
        stepN    = (remaining < SHAMT_WIDTH'(STEP)) ? remaining : SHAMT_WIDTH'(STEP);
        wrapAmt  = WRAP_WIDTH'(DATA_WIDTH) - WRAP_WIDTH'(stepN);
        lastStep = (remaining == stepN);
        stepped  = work;
        case (opCode)
            OP_SLL:  stepped = work << stepN;
            OP_SRL:  stepped = work >> stepN;
            OP_SRA:  stepped = $unsigned($signed(work) >>> stepN);
            OP_ROL:  stepped = (work << stepN) | (work >> wrapAmt);
            OP_ROR:  stepped = (work >> stepN) | (work << wrapAmt);
            OP_SL2:  stepped = {work[DATA_WIDTH-3:0], 2'b00};
            default: stepped = work;
        endcase
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            opCode    <= OP_SLL;
            remaining <= '0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
            resultQ   <= '0;
            opErrQ    <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work      <= bus.data_in;
                        opCode    <= bus.op;
                        remaining <= startOneShot ? '0 : bus.shamt;
                        busyQ     <= 1'b1;
                        opErrQ    <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    work      <= stepped;
                    remaining <= remaining - stepN;
                    if (lastStep) begin
                        busyQ   <= 1'b0;
                        doneQ   <= 1'b1;
                        resultQ <= stepped;
                        opErrQ  <= opIllegal;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busyQ <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: one instance at STEP=1, one at STEP=4.
module tb_shift_unit;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;

    localparam logic [2:0] SLL = 3'b000;
    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROL = 3'b011;
    localparam logic [2:0] ROR = 3'b100;
    localparam logic [2:0] SL2 = 3'b101;

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        int            doneCyc;
    } expT;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    expT  q1[$];
    expT  q4[$];
    expT  m1;
    expT  m4;

    shift_unit_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus1 ();
    shift_unit_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus4 ();

    shift_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW), .STEP(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    shift_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW), .STEP(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    always #5 clk = ~clk;

    // Edge index: after edge n, cyc == n
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one start pulse; when accept is set, queue the expected completion
    task automatic issue(input bit wide, input logic [2:0] op, input logic [SW-1:0] sh,
                         input logic [DW-1:0] d, input bit accept,
                         input logic [DW-1:0] expRes, input logic expErr, input int lat);
        expT e;
        if (wide) begin
            bus4.start = 1'b1; bus4.op = op; bus4.shamt = sh; bus4.data_in = d;
        end else begin
            bus1.start = 1'b1; bus1.op = op; bus1.shamt = sh; bus1.data_in = d;
        end
        if (accept) begin
            e.res = expRes;
            e.err = expErr;
            e.doneCyc = cyc + 1 + lat;
            if (wide) q4.push_back(e);
            else q1.push_back(e);
        end
        @(negedge clk);
        bus1.start = 1'b0;
        bus4.start = 1'b0;
    endtask

    // Wait (bounded) until every queued completion has been observed
    task automatic drain(input bit wide);
        int n = 0;
        while (((wide ? q4.size() : q1.size()) != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(wide ? "s4 drained" : "s1 drained", wide ? q4.size() : q1.size(), 0);
    endtask

    // Monitor: compare every done pulse against the head of its scoreboard queue
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus1.done === 1'b1) begin
                if (q1.size() == 0) check("s1 spurious done", bus1.done, 0);
                else begin
                    m1 = q1.pop_front();
                    check("s1 result", bus1.result, m1.res);
                    check("s1 op_err", bus1.op_err, m1.err);
                    check("s1 done cycle", cyc, m1.doneCyc);
                    check("s1 busy at done", bus1.busy, 0);
                end
            end
            if (bus4.done === 1'b1) begin
                if (q4.size() == 0) check("s4 spurious done", bus4.done, 0);
                else begin
                    m4 = q4.pop_front();
                    check("s4 result", bus4.result, m4.res);
                    check("s4 op_err", bus4.op_err, m4.err);
                    check("s4 done cycle", cyc, m4.doneCyc);
                    check("s4 busy at done", bus4.busy, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus1.start = 1'b0; bus1.op = SLL; bus1.shamt = '0; bus1.data_in = '0;
        bus4.start = 1'b0; bus4.op = SLL; bus4.shamt = '0; bus4.data_in = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        // Reset state, with start high to show reset wins
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check("rst s1 busy", bus1.busy, 0);
        check("rst s1 done", bus1.done, 0);
        check("rst s1 result", bus1.result, 0);
        check("rst s1 op_err", bus1.op_err, 0);
        check("rst s4 busy", bus4.busy, 0);
        check("rst s4 done", bus4.done, 0);
        check("rst s4 result", bus4.result, 0);
        reset = 1'b0;
        @(negedge clk);

        // T1: full-width shift one bit per clock, busy through k..k+14
        issue(0, SLL, 4'd15, 16'h0001, 1, 16'h8000, 0, 15);
        check("T1 busy at k", bus1.busy, 1);
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            check("T1 busy", bus1.busy, 1);
        end
        drain(0);

        // T2: STEP=4 instance
        issue(1, SRA, 4'd4, 16'h8000, 1, 16'hF800, 0, 1);
        drain(1);
        issue(1, SRL, 4'd4, 16'h8000, 1, 16'h0800, 0, 1);
        drain(1);
        issue(1, SLL, 4'd15, 16'h0001, 1, 16'h8000, 0, 4);
        drain(1);
        issue(1, ROR, 4'd6, 16'h1234, 1, 16'hD048, 0, 2);
        drain(1);
        issue(1, 3'b110, 4'd3, 16'h5A5A, 1, 16'h5A5A, 1, 1);
        drain(1);

        // T3: rotates, fixed shift-by-2, max arithmetic shift
        issue(0, ROR, 4'd1, 16'h0001, 1, 16'h8000, 0, 1);
        drain(0);
        issue(0, ROL, 4'd4, 16'h8001, 1, 16'h0018, 0, 4);
        drain(0);
        issue(0, SL2, 4'd7, 16'h3FFF, 1, 16'hFFFC, 0, 1);
        drain(0);
        issue(0, SRA, 4'd15, 16'h8000, 1, 16'hFFFF, 0, 15);
        drain(0);

        // T4: zero shift, then back-to-back start in the done cycle
        issue(0, SLL, 4'd0, 16'hA5A5, 1, 16'hA5A5, 0, 1);
        @(negedge clk);
        check("T4 done before b2b", bus1.done, 1);
        issue(0, SRL, 4'd8, 16'hA5A5, 1, 16'h00A5, 0, 8);
        check("T4 done dropped", bus1.done, 0);
        check("T4 busy after b2b", bus1.busy, 1);
        drain(0);

        // T5: start while busy is ignored; illegal op flags op_err
        issue(0, SRL, 4'd4, 16'h1234, 1, 16'h0123, 0, 4);
        @(negedge clk);
        issue(0, SLL, 4'd1, 16'hFFFF, 0, 16'h0000, 0, 0);
        drain(0);
        issue(0, 3'b111, 4'd5, 16'hBEEF, 1, 16'hBEEF, 1, 1);
        drain(0);
        issue(0, SLL, 4'd1, 16'h0003, 1, 16'h0006, 0, 1);
        drain(0);

        // T6: reset mid-shift aborts with no later done
        issue(0, SLL, 4'd10, 16'h0001, 0, 16'h0000, 0, 0);
        repeat (3) @(negedge clk);
        check("T6 busy mid-shift", bus1.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("T6 busy", bus1.busy, 0);
        check("T6 done", bus1.done, 0);
        check("T6 result", bus1.result, 0);
        check("T6 op_err", bus1.op_err, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("T6 still idle", bus1.busy, 0);
        drain(0);
        drain(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
